// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the MEM-stage result, selects write-back data,
// drives the register-file bypass and keeps saturating hold/bubble statistics.
module mem_wb_stage #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned REG_ADDR_W   = 3,
  parameter int unsigned STALL_W      = 6,
  parameter int unsigned UP_BIT       = 1,
  parameter int unsigned DN_BIT       = 0,
  parameter int unsigned R0_HARDWIRED = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [STALL_W-1:0]    stall_i,
  input  logic                  flush_i,
  input  logic                  mem_valid_i,
  input  logic [DATA_W-1:0]     mem_memData_i,
  input  logic [DATA_W-1:0]     mem_aluResult_i,
  input  logic [REG_ADDR_W-1:0] mem_reg3_i,
  input  logic                  mem_resultOrMem_i,
  input  logic                  mem_regWrite_i,
  input  logic                  stat_clr_i,
  output logic [DATA_W-1:0]     wb_memData_o,
  output logic [DATA_W-1:0]     wb_aluResult_o,
  output logic [REG_ADDR_W-1:0] wb_reg3_o,
  output logic                  wb_resultOrMem_o,
  output logic                  wb_regWrite_o,
  output logic                  wb_valid_o,
  output logic [DATA_W-1:0]     wb_writeData_o,
  output logic                  fwd_en_o,
  output logic [REG_ADDR_W-1:0] fwd_reg_o,
  output logic [DATA_W-1:0]     fwd_data_o,
  output logic [CNT_W-1:0]      stat_stall_o,
  output logic [CNT_W-1:0]      stat_bubble_o
);

  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_HOLD,
    ACT_BUBBLE
  } act_e;

  act_e act;
  logic up;
  logic dn;
  logic r0_block;

  assign up       = stall_i[UP_BIT];
  assign dn       = stall_i[DN_BIT];
  assign r0_block = (R0_HARDWIRED == 1) && (mem_reg3_i == '0);

  // Flush outranks hold, so a flush during a full stall is counted as a bubble only.
  always_comb begin
    act = ACT_CAPTURE;
    if (flush_i)      act = ACT_BUBBLE;
    else if (up && dn) act = ACT_HOLD;
    else if (up)       act = ACT_BUBBLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_memData_o     <= '0;
      wb_aluResult_o   <= '0;
      wb_reg3_o        <= '0;
      wb_resultOrMem_o <= 1'b0;
      wb_regWrite_o    <= 1'b0;
      wb_valid_o       <= 1'b0;
    end else begin
      case (act)
        ACT_HOLD: ;
        ACT_BUBBLE: begin
          wb_memData_o     <= '0;
          wb_aluResult_o   <= '0;
          wb_reg3_o        <= '0;
          wb_resultOrMem_o <= 1'b0;
          wb_regWrite_o    <= 1'b0;
          wb_valid_o       <= 1'b0;
        end
        default: begin
          wb_memData_o     <= mem_memData_i;
          wb_aluResult_o   <= mem_aluResult_i;
          wb_reg3_o        <= mem_reg3_i;
          wb_resultOrMem_o <= mem_resultOrMem_i;
          wb_regWrite_o    <= mem_regWrite_i && mem_valid_i && !r0_block;
          wb_valid_o       <= mem_valid_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clr_i) begin
      stat_stall_o  <= '0;
      stat_bubble_o <= '0;
    end else begin
      if (act == ACT_HOLD && stat_stall_o != '1)
        stat_stall_o <= stat_stall_o + CNT_W'(1);
      if (act == ACT_BUBBLE && stat_bubble_o != '1)
        stat_bubble_o <= stat_bubble_o + CNT_W'(1);
    end
  end

  assign wb_writeData_o = wb_resultOrMem_o ? wb_memData_o : wb_aluResult_o;
  assign fwd_en_o       = wb_regWrite_o && wb_valid_o;
  assign fwd_reg_o      = wb_reg3_o;
  assign fwd_data_o     = wb_writeData_o;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage: stimulus pushes hand-computed results into
// a queue, a monitor pops and compares them after every following clock edge.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic [15:0] mem_memData_i = '0;
  logic [15:0] mem_aluResult_i = '0;
  logic [2:0]  mem_reg3_i = '0;
  logic        mem_resultOrMem_i = 1'b0;
  logic        mem_regWrite_i = 1'b0;
  logic        stat_clr_i = 1'b0;

  logic [15:0] wb_memData_o, wb_aluResult_o, wb_writeData_o, fwd_data_o;
  logic [2:0]  wb_reg3_o, fwd_reg_o;
  logic        wb_resultOrMem_o, wb_regWrite_o, wb_valid_o, fwd_en_o;
  logic [15:0] stat_stall_o, stat_bubble_o;

  logic [15:0] s_memData, s_aluResult, s_writeData, s_fwdData;
  logic [2:0]  s_reg3, s_fwdReg;
  logic        s_rom, s_rw, s_valid, s_fwdEn;
  logic [3:0]  s_stall, s_bubble;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .mem_valid_i(mem_valid_i), .mem_memData_i(mem_memData_i),
    .mem_aluResult_i(mem_aluResult_i), .mem_reg3_i(mem_reg3_i),
    .mem_resultOrMem_i(mem_resultOrMem_i), .mem_regWrite_i(mem_regWrite_i),
    .stat_clr_i(stat_clr_i),
    .wb_memData_o(wb_memData_o), .wb_aluResult_o(wb_aluResult_o),
    .wb_reg3_o(wb_reg3_o), .wb_resultOrMem_o(wb_resultOrMem_o),
    .wb_regWrite_o(wb_regWrite_o), .wb_valid_o(wb_valid_o),
    .wb_writeData_o(wb_writeData_o), .fwd_en_o(fwd_en_o),
    .fwd_reg_o(fwd_reg_o), .fwd_data_o(fwd_data_o),
    .stat_stall_o(stat_stall_o), .stat_bubble_o(stat_bubble_o)
  );

  // Narrow-counter copy sharing all inputs, used to observe saturation.
  mem_wb_stage #(.CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .mem_valid_i(mem_valid_i), .mem_memData_i(mem_memData_i),
    .mem_aluResult_i(mem_aluResult_i), .mem_reg3_i(mem_reg3_i),
    .mem_resultOrMem_i(mem_resultOrMem_i), .mem_regWrite_i(mem_regWrite_i),
    .stat_clr_i(stat_clr_i),
    .wb_memData_o(s_memData), .wb_aluResult_o(s_aluResult),
    .wb_reg3_o(s_reg3), .wb_resultOrMem_o(s_rom),
    .wb_regWrite_o(s_rw), .wb_valid_o(s_valid),
    .wb_writeData_o(s_writeData), .fwd_en_o(s_fwdEn),
    .fwd_reg_o(s_fwdReg), .fwd_data_o(s_fwdData),
    .stat_stall_o(s_stall), .stat_bubble_o(s_bubble)
  );

  typedef struct {
    logic        valid, rw, rom;
    logic [2:0]  r3;
    logic [15:0] md, alu, wd, ss, sb;
    logic [3:0]  ss4, sb4;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t E(input logic valid, input logic rw, input logic rom,
                             input logic [2:0] r3, input logic [15:0] md,
                             input logic [15:0] alu, input logic [15:0] wd,
                             input logic [15:0] ss, input logic [15:0] sb,
                             input logic [3:0] ss4, input logic [3:0] sb4);
    exp_t e;
    e.valid = valid; e.rw = rw; e.rom = rom; e.r3 = r3; e.md = md; e.alu = alu;
    e.wd = wd; e.ss = ss; e.sb = sb; e.ss4 = ss4; e.sb4 = sb4;
    return e;
  endfunction

  task automatic v(input logic r, input logic [5:0] st, input logic fl, input logic vl,
                   input logic [15:0] md, input logic [15:0] alu, input logic [2:0] r3,
                   input logic rom, input logic rw, input logic clr, input exp_t e);
    @(negedge clk);
    rst_i = r; stall_i = st; flush_i = fl; mem_valid_i = vl;
    mem_memData_i = md; mem_aluResult_i = alu; mem_reg3_i = r3;
    mem_resultOrMem_i = rom; mem_regWrite_i = rw; stat_clr_i = clr;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      chk("wb_valid",      32'(wb_valid_o),       32'(cur.valid));
      chk("wb_regWrite",   32'(wb_regWrite_o),    32'(cur.rw));
      chk("wb_resultOrMem",32'(wb_resultOrMem_o), 32'(cur.rom));
      chk("wb_reg3",       32'(wb_reg3_o),        32'(cur.r3));
      chk("wb_memData",    32'(wb_memData_o),     32'(cur.md));
      chk("wb_aluResult",  32'(wb_aluResult_o),   32'(cur.alu));
      chk("wb_writeData",  32'(wb_writeData_o),   32'(cur.wd));
      chk("fwd_en",        32'(fwd_en_o),         32'(cur.valid & cur.rw));
      chk("fwd_reg",       32'(fwd_reg_o),        32'(cur.r3));
      chk("fwd_data",      32'(fwd_data_o),       32'(cur.wd));
      chk("stat_stall",    32'(stat_stall_o),     32'(cur.ss));
      chk("stat_bubble",   32'(stat_bubble_o),    32'(cur.sb));
      chk("sat_stall",     32'(s_stall),          32'(cur.ss4));
      chk("sat_bubble",    32'(s_bubble),         32'(cur.sb4));
    end
  end

  initial begin
    exp_t z;
    z = E(0,0,0,0,16'h0,16'h0,16'h0,0,0,0,0);
    // reset
    v(1,6'b000000,0,1,16'h1111,16'h2222,3'd3,0,1,0, z);
    // capture ALU op, then load select
    v(0,6'b000000,0,1,16'h0000,16'h1234,3'd5,0,1,0, E(1,1,0,5,16'h0000,16'h1234,16'h1234,0,0,0,0));
    v(0,6'b000000,0,1,16'hBEEF,16'h0001,3'd2,1,1,0, E(1,1,1,2,16'hBEEF,16'h0001,16'hBEEF,0,0,0,0));
    // hold x3 with changing inputs
    v(0,6'b000011,0,0,16'hAAAA,16'h5555,3'd7,0,0,0, E(1,1,1,2,16'hBEEF,16'h0001,16'hBEEF,1,0,1,0));
    v(0,6'b000011,0,1,16'h1357,16'h2468,3'd6,0,1,0, E(1,1,1,2,16'hBEEF,16'h0001,16'hBEEF,2,0,2,0));
    v(0,6'b000011,0,1,16'hFFFF,16'hFFFF,3'd1,1,0,0, E(1,1,1,2,16'hBEEF,16'h0001,16'hBEEF,3,0,3,0));
    // capture while clearing counters
    v(0,6'b000000,0,1,16'h0000,16'h00FF,3'd1,0,1,1, E(1,1,0,1,16'h0000,16'h00FF,16'h00FF,0,0,0,0));
    // bubble, then flush during full stall
    v(0,6'b000010,0,1,16'h0001,16'h0002,3'd3,1,1,0, E(0,0,0,0,16'h0,16'h0,16'h0,0,1,0,1));
    v(0,6'b000011,1,1,16'h0003,16'h0004,3'd4,1,1,0, E(0,0,0,0,16'h0,16'h0,16'h0,0,2,0,2));
    // write to r0 suppressed; invalid instruction never writes
    v(0,6'b000000,0,1,16'h0000,16'h0042,3'd0,0,1,0, E(1,0,0,0,16'h0000,16'h0042,16'h0042,0,2,0,2));
    v(0,6'b000000,0,0,16'h0000,16'h0777,3'd4,0,1,0, E(0,0,0,4,16'h0000,16'h0777,16'h0777,0,2,0,2));
    // unrelated stall bits do not stall this stage
    v(0,6'b111100,0,1,16'h0000,16'h0606,3'd6,0,1,0, E(1,1,0,6,16'h0000,16'h0606,16'h0606,0,2,0,2));
    // clear in a hold cycle wins over the increment
    v(0,6'b000011,0,1,16'h9999,16'h8888,3'd1,1,0,1, E(1,1,0,6,16'h0000,16'h0606,16'h0606,0,0,0,0));
    v(0,6'b000011,0,1,16'h9999,16'h8888,3'd1,1,0,0, E(1,1,0,6,16'h0000,16'h0606,16'h0606,1,0,1,0));
    // reset in the middle of a hold, alongside flush
    v(1,6'b000011,1,1,16'h9999,16'h8888,3'd1,1,1,0, z);
    v(0,6'b000000,0,1,16'h0000,16'h1234,3'd5,0,1,0, E(1,1,0,5,16'h0000,16'h1234,16'h1234,0,0,0,0));
    // 20 holds: wide counter counts on, narrow one pins at 15
    for (int k = 1; k <= 20; k++)
      v(0,6'b000011,0,0,16'hAAAA,16'(k),3'd7,1,0,0,
        E(1,1,0,5,16'h0000,16'h1234,16'h1234,16'(k),0,4'((k > 15) ? 15 : k),0));
    // 17 flushes: bubble counter saturates likewise
    for (int k = 1; k <= 17; k++)
      v(0,6'b000000,1,1,16'h5A5A,16'(k),3'd3,0,1,0,
        E(0,0,0,0,16'h0,16'h0,16'h0,16'd20,16'(k),4'd15,4'((k > 15) ? 15 : k)));
    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
